// File: rtl/pipe_pkg.sv
// Shared widths, op codes and payload layout for the pipeline stage buffers.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned OP_W_DEF   = 3;

    localparam logic [OP_W_DEF-1:0] OP_NOP    = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_ALU    = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_LOAD   = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_STORE  = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_BRANCH = 3'd4;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [REG_W_DEF-1:0]  rs2;
        logic [REG_W_DEF-1:0]  rsd;
        logic [OP_W_DEF-1:0]   op;
    } pipe_payload_t;

    // Flattened payload width for a given field configuration.
    function automatic int unsigned payload_width(input int unsigned dw,
                                                  input int unsigned rw,
                                                  input int unsigned ow);
        return dw + 2 * rw + ow;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload+valid register; clear beats load, reset beats both.
module pipe_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            q_o     <= '0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            q_o     <= d_i;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register with backpressure, flush, forwarding tap and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready_o.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [REG_W-1:0]  rs2_i,
    input  logic [REG_W-1:0]  rsd_i,
    input  logic [OP_W-1:0]   op_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [REG_W-1:0]  rs2_o,
    output logic [REG_W-1:0]  rsd_o,
    output logic [OP_W-1:0]   op_o,
    output logic              fwd_valid_o,
    output logic [REG_W-1:0]  fwd_rsd_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned PL_W = payload_width(DATA_W, REG_W, OP_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PL_W-1:0] in_pl;
    logic [PL_W-1:0] main_d;
    logic [PL_W-1:0] main_pl;
    logic            main_v;
    logic            main_clr;
    logic            main_load;
    logic            in_fire;
    logic [CNT_W-1:0] stall_q;

    assign in_pl   = {data_i, rs2_i, rsd_i, op_i};
    assign in_fire = in_valid_i && in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
    logic            main_free;
    logic            skid_v;
    logic            skid_clr;
    logic            skid_load;
    logic            skid_nxt;
    logic            rdy_q;
    logic [PL_W-1:0] skid_pl;

    // in_fire implies the skid slot is empty, so skid and input never compete for the main slot.
    assign main_free = !main_v || out_ready_i;
    assign main_load = main_free && (skid_v || in_fire);
    assign main_clr  = flush_i || (main_free && !skid_v && !in_fire);
    assign main_d    = skid_v ? skid_pl : in_pl;
    assign skid_load = !main_free && in_fire;
    assign skid_clr  = flush_i || (main_free && skid_v);

    always_comb begin
        skid_nxt = skid_v;
        if (skid_clr) begin
            skid_nxt = 1'b0;
        end else if (skid_load) begin
            skid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= !skid_nxt;
        end
    end

    assign in_ready_o = rdy_q;

    pipe_skid_slot #(.W(PL_W)) u_skid_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (skid_clr),
        .load_i  (skid_load),
        .d_i     (in_pl),
        .valid_o (skid_v),
        .q_o     (skid_pl)
    );
`else
    logic out_fire;

    // A new beat replaces a departing one in the same cycle, so no bubble.
    assign out_fire   = main_v && out_ready_i;
    assign in_ready_o = !rst_i && (!main_v || out_ready_i);
    assign main_load  = in_fire;
    assign main_clr   = flush_i || (out_fire && !in_fire);
    assign main_d     = in_pl;
`endif

    pipe_skid_slot #(.W(PL_W)) u_main_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (main_clr),
        .load_i  (main_load),
        .d_i     (main_d),
        .valid_o (main_v),
        .q_o     (main_pl)
    );

    // Saturating count of cycles the output beat was refused downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (main_v && !out_ready_i && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_valid_o                    = main_v;
    assign {data_o, rs2_o, rsd_o, op_o}   = main_pl;
    assign fwd_valid_o                    = main_v && (rsd_o != '0);
    assign fwd_rsd_o                      = rsd_o;
    assign fwd_data_o                     = data_o;
    assign stall_cnt_o                    = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf; a CNT_W=2 twin shares the stimulus for saturation checks.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [4:0]  rsd_i = '0;
    logic [2:0]  op_i = '0;
    logic        out_ready_i = 1'b0;

    logic        in_ready_o, out_valid_o, fwd_valid_o;
    logic [31:0] data_o, fwd_data_o;
    logic [4:0]  rs2_o, rsd_o, fwd_rsd_o;
    logic [2:0]  op_o;
    logic [15:0] stall_cnt_o;

    logic        s_in_ready, s_out_valid, s_fwd_valid;
    logic [31:0] s_data, s_fwd_data;
    logic [4:0]  s_rs2, s_rsd, s_fwd_rsd;
    logic [2:0]  s_op;
    logic [1:0]  s_stall_cnt;

    int tests = 0;
    int fails = 0;
    pipe_payload_t sb[$];

`ifdef PIPE_STAGE_SKID_EN
    localparam logic EXP_RDY_STALLED = 1'b1;
`else
    localparam logic EXP_RDY_STALLED = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    pipe_stage_buf dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .rs2_i(rs2_i), .rsd_i(rsd_i), .op_i(op_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .rs2_o(rs2_o), .rsd_o(rsd_o), .op_o(op_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rsd_o(fwd_rsd_o), .fwd_data_o(fwd_data_o),
        .stall_cnt_o(stall_cnt_o)
    );

    pipe_stage_buf #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .data_i(data_i), .rs2_i(rs2_i), .rsd_i(rsd_i), .op_i(op_i),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .data_o(s_data), .rs2_o(s_rs2), .rsd_o(s_rsd), .op_o(s_op),
        .fwd_valid_o(s_fwd_valid), .fwd_rsd_o(s_fwd_rsd), .fwd_data_o(s_fwd_data),
        .stall_cnt_o(s_stall_cnt)
    );

    // Scoreboard: push accepted beats, pop and compare on every output transfer.
    always @(negedge clk_i) begin
        pipe_payload_t exp_pl;
        pipe_payload_t got_pl;
        if (rst_i) begin
            sb.delete();
        end else begin
            if (out_valid_o === 1'b1 && out_ready_i) begin
                tests++;
                got_pl = {data_o, rs2_o, rsd_o, op_o};
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got beat %h, required no beat", got_pl);
                end else begin
                    exp_pl = sb.pop_front();
                    if (got_pl !== exp_pl) begin
                        fails++;
                        $display("FAIL sb_payload: got %h, required %h", got_pl, exp_pl);
                    end
                end
            end
            if (flush_i) begin
                sb.delete();
            end else if (in_valid_i && in_ready_o === 1'b1) begin
                sb.push_back({data_i, rs2_i, rsd_i, op_i});
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [2:0] op);
        in_valid_i = 1'b1;
        data_i = d;
        rs2_i = r2;
        rsd_i = rd;
        op_i = op;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", out_valid_o); end
        tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b, required 0", in_ready_o); end
        tests++; if ({data_o, rs2_o, rsd_o, op_o} !== '0) begin fails++; $display("FAIL rst_payload: got %h, required 0", {data_o, rs2_o, rsd_o, op_o}); end
        tests++; if (fwd_valid_o !== 1'b0) begin fails++; $display("FAIL rst_fwd_valid: got %b, required 0", fwd_valid_o); end
        tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL rst_stall: got %0d, required 0", stall_cnt_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rel_in_ready: got %b, required 1", in_ready_o); end
    endtask

    task automatic test_basic;
        @(posedge clk_i); #1;
        drive(32'h0000_00AA, 5'd3, 5'd5, OP_ALU);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b, required 1", out_valid_o); end
        tests++; if (data_o !== 32'hAA) begin fails++; $display("FAIL basic_data: got %h, required aa", data_o); end
        tests++; if (fwd_valid_o !== 1'b1) begin fails++; $display("FAIL basic_fwd_valid: got %b, required 1", fwd_valid_o); end
        tests++; if (fwd_rsd_o !== 5'd5) begin fails++; $display("FAIL basic_fwd_rsd: got %0d, required 5", fwd_rsd_o); end
        tests++; if (fwd_data_o !== 32'hAA) begin fails++; $display("FAIL basic_fwd_data: got %h, required aa", fwd_data_o); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            drive(32'(i + 1), 5'(i), 5'((i % 7) + 1), OP_ALU);
            @(negedge clk_i);
            tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready_o); end
            if (i > 0) begin
                tests++;
                if (out_valid_o !== 1'b1 || data_o !== 32'(i)) begin
                    fails++;
                    $display("FAIL b2b_out[%0d]: got valid %b data %0d, required valid 1 data %0d", i, out_valid_o, data_o, i);
                end
            end
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b1 || data_o !== 32'd8) begin fails++; $display("FAIL b2b_last: got valid %b data %0d, required valid 1 data 8", out_valid_o, data_o); end
        tests++; if (stall_cnt_o !== 16'd0) begin fails++; $display("FAIL b2b_stall: got %0d, required 0", stall_cnt_o); end
    endtask

    task automatic test_backpressure;
        @(posedge clk_i); #1;
        drive(32'h100, 5'd1, 5'd7, OP_LOAD);
        out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        drive(32'h200, 5'd2, 5'd8, OP_STORE);
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b1 || data_o !== 32'h100) begin fails++; $display("FAIL bp_held: got valid %b data %h, required valid 1 data 100", out_valid_o, data_o); end
        tests++; if (in_ready_o !== EXP_RDY_STALLED) begin fails++; $display("FAIL bp_ready0: got %b, required %b", in_ready_o, EXP_RDY_STALLED); end
        @(posedge clk_i); #1;
`ifdef PIPE_STAGE_SKID_EN
        in_valid_i = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (stall_cnt_o !== 16'd4) begin fails++; $display("FAIL bp_stall4: got %0d, required 4", stall_cnt_o); end
        tests++; if (data_o !== 32'h100) begin fails++; $display("FAIL bp_data_kept: got %h, required 100", data_o); end
        tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b, required 0", in_ready_o); end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b1 || data_o !== 32'h200) begin fails++; $display("FAIL bp_next: got valid %b data %h, required valid 1 data 200", out_valid_o, data_o); end
        tests++; if (stall_cnt_o !== 16'd5) begin fails++; $display("FAIL bp_stall5: got %0d, required 5", stall_cnt_o); end
    endtask

    task automatic test_flush;
        @(posedge clk_i); #1;
        drive(32'h300, 5'd3, 5'd9, OP_ALU);
        out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        drive(32'h400, 5'd4, 5'd10, OP_ALU);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b, required 0", out_valid_o); end
        tests++; if (stall_cnt_o !== 16'd6) begin fails++; $display("FAIL flush_stall: got %0d, required 6", stall_cnt_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b, required 1", in_ready_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got valid %b data %h, required valid 0", i, out_valid_o, data_o); end
        end
    endtask

    task automatic test_fwd_zero;
        @(posedge clk_i); #1;
        drive(32'h55, 5'd4, 5'd0, OP_BRANCH);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL fz_valid: got %b, required 1", out_valid_o); end
        tests++; if (fwd_valid_o !== 1'b0) begin fails++; $display("FAIL fz_fwd_valid: got %b, required 0", fwd_valid_o); end
        tests++; if (fwd_data_o !== 32'h55 || fwd_rsd_o !== 5'd0) begin fails++; $display("FAIL fz_fwd: got data %h rsd %0d, required data 55 rsd 0", fwd_data_o, fwd_rsd_o); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            in_valid_i = 1'($urandom_range(0, 1));
            data_i = $urandom;
            rs2_i = 5'($urandom);
            rsd_i = 5'($urandom);
            op_i = 3'($urandom_range(0, 4));
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL rand_drain: got %0d beats pending, required 0", sb.size()); end
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rand_idle: got %b, required 0", out_valid_o); end
    endtask

    task automatic test_saturation;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        drive(32'h777, 5'd1, 5'd2, OP_ALU);
        out_ready_i = 1'b0;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (s_stall_cnt !== 2'd3) begin fails++; $display("FAIL sat_cnt: got %0d, required 3", s_stall_cnt); end
        tests++; if (stall_cnt_o !== 16'd6) begin fails++; $display("FAIL sat_wide_cnt: got %0d, required 6", stall_cnt_o); end
        tests++; if (out_valid_o !== 1'b1 || data_o !== 32'h777) begin fails++; $display("FAIL sat_held: got valid %b data %h, required valid 1 data 777", out_valid_o, data_o); end
    endtask

    task automatic test_reset_mid_stall;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rms_valid: got %b, required 0", out_valid_o); end
        tests++; if (stall_cnt_o !== 16'd0 || s_stall_cnt !== 2'd0) begin fails++; $display("FAIL rms_stall: got %0d/%0d, required 0/0", stall_cnt_o, s_stall_cnt); end
        tests++; if (in_ready_o !== 1'b0) begin fails++; $display("FAIL rms_ready: got %b, required 0", in_ready_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL rms_rel_ready: got %b, required 1", in_ready_o); end
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rms_no_beat: got %b, required 0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_fwd_zero();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the CPU datapath. It generalises the fixed EX/MEM buffer and can sit at any inter-stage boundary (ID/EX, EX/MEM, MEM/WB).
- Carries a configurable payload: result data, two register indices and an op code, plus a valid bit.
- Adds valid/ready backpressure, flush, a forwarding tap and a saturating stall counter.
- Single rising-edge design; all state is updated on posedge clk_i.

Parameters:
- DATA_W, 32, width of the result/data field.
- REG_W, 5, width of each register-index field (rs2, rsd).
- OP_W, 3, width of the op-code field.
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill the stage contents and any incoming beat this cycle.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- data_i  in  DATA_W  result/data payload.
- rs2_i  in  REG_W  source register 2 index.
- rsd_i  in  REG_W  destination register index.
- op_i  in  OP_W  op code.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- data_o, rs2_o, rsd_o, op_o  out  as inputs  registered payload.
- fwd_valid_o  out  1  high when out_valid_o=1 and rsd_o!=0.
- fwd_rsd_o  out  REG_W  equals rsd_o.
- fwd_data_o  out  DATA_W  equals data_o.
- stall_cnt_o  out  CNT_W  saturating count of backpressured cycles.

Behaviour:
- Reset:
  - rst_i is sampled on posedge clk_i.
  - After reset: out_valid_o=0; all payload outputs=0; fwd_valid_o=0; stall_cnt_o=0.
  - in_ready_o=0 while rst_i=1 and 1 on the first cycle after release.
  - Reset mid-transfer discards held beats; no beat is emitted.
- Handshakes:
  - A transfer in occurs when in_valid_i && in_ready_o.
  - A transfer out occurs when out_valid_o && out_ready_i.
  - Payload is captured only on a transfer in. When held, outputs keep their values.
- Latency: exactly 1 cycle from input transfer to out_valid_o, when the stage is empty.
- Base mode (macro undefined):
  - Single register slot.
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Simultaneous transfer out and transfer in: the new beat replaces the old with no bubble.
- Flush:
  - On flush_i=1, next cycle out_valid_o=0.
  - An incoming beat in the same cycle is dropped.
  - Flush takes priority over capture and over reset-release.
  - Payload registers may retain stale values; outputs are only meaningful while out_valid_o=1.
  - flush_i does not affect stall_cnt_o.
- Stall counter:
  - Increments each cycle with out_valid_o && !out_ready_i.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by rst_i.
- Forwarding tap: purely combinational from the output registers; no extra latency.
- Ordering: beats leave in arrival order; no duplication, no loss except by flush/reset.

Optional Feature:
- Macro PIPE_STAGE_SKID_EN.
- Defined:
  - Adds a second skid slot, giving 2 entries.
  - in_ready_o becomes a register (= skid slot empty), with no combinational path from out_ready_i.
  - When the output is stalled and a beat arrives, it is parked in the skid slot.
  - The skid slot drains to the output on the next transfer out.
  - Throughput stays 1 beat/cycle; latency stays 1 cycle when empty.
  - Flush empties both slots.
- Undefined: base single-slot behaviour as above.

Decomposition:
- Package pipe_pkg holds:
  - REG_W and OP_W defaults.
  - Op-code localparams: OP_NOP=0, OP_ALU=1, OP_LOAD=2, OP_STORE=3, OP_BRANCH=4.
  - A packed payload struct typedef built from these.
- Sub-module pipe_skid_slot:
  - One payload+valid register with load/clear controls.
  - Instantiated once in base mode and twice with PIPE_STAGE_SKID_EN.

Test Plan:
- Reset, then in_valid_i=1 with data_i=0x0000_00AA, rsd_i=5, out_ready_i=1 → next cycle out_valid_o=1, data_o=0xAA, fwd_valid_o=1, fwd_rsd_o=5.
- Streaming: 8 back-to-back beats data 1..8 with out_ready_i=1 → outputs 1..8 on consecutive cycles, no bubbles, stall_cnt_o=0.
- Backpressure: hold out_ready_i=0 for 4 cycles with a beat held → stall_cnt_o=4, data_o unchanged.
  - Base mode: in_ready_o=0.
  - Skid mode: one extra beat is accepted, then in_ready_o=0.
- Flush with beat held and in_valid_i=1 → next cycle out_valid_o=0; the incoming beat never appears.
- rsd_i=0 beat → out_valid_o=1, fwd_valid_o=0.
- CNT_W=2 with 6 stalled cycles → stall_cnt_o saturates at 3.
- rst_i asserted mid-stall → out_valid_o=0 and stall_cnt_o=0 next cycle.
